// File: rtl/nor_adder2_dual.sv
// Registered 2-bit adder with carry-in, computed on a NOR-only gate path and a behavioural
// path in parallel; the two registered results are compared and mismatches are counted.
module nor_adder2_dual #(
    parameter int          GATE_DELAY = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       a,
    input  logic [1:0]       b,
    input  logic             cin,
    output logic             out_valid,
    output logic [1:0]       sum_nor,
    output logic             cout_nor,
    output logic [1:0]       sum_ref,
    output logic             cout_ref,
    output logic             mismatch,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    // GATE_DELAY only models timing in simulation; the registered results never depend on it.
    if (GATE_DELAY < 0) begin : g_bad_delay
        $error("nor_adder2_dual: GATE_DELAY must be non-negative");
    end

    function automatic logic nor2(input logic x, input logic y);
        return ~(x | y);
    endfunction

    // ---------------------------------------------------------------- NOR path, bit 0
    logic b0_n1, b0_n2, b0_n3, b0_xn;
    logic b0_m1, b0_m2, b0_m3, b0_sum;
    logic b0_na, b0_nb, b0_ab, b0_nc, b0_cp, b0_cn, b0_cout;

    // sum = xnor(xnor(a, b), c); each xnor is four NORs
    assign b0_n1   = nor2(a[0], b[0]);
    assign b0_n2   = nor2(a[0], b0_n1);
    assign b0_n3   = nor2(b[0], b0_n1);
    assign b0_xn   = nor2(b0_n2, b0_n3);
    assign b0_m1   = nor2(b0_xn, cin);
    assign b0_m2   = nor2(b0_xn, b0_m1);
    assign b0_m3   = nor2(cin, b0_m1);
    assign b0_sum  = nor2(b0_m2, b0_m3);

    // carry = a&b | c&(a^b); c&(a^b) is nor(~c, xnor(a, b))
    assign b0_na   = nor2(a[0], a[0]);
    assign b0_nb   = nor2(b[0], b[0]);
    assign b0_ab   = nor2(b0_na, b0_nb);
    assign b0_nc   = nor2(cin, cin);
    assign b0_cp   = nor2(b0_nc, b0_xn);
    assign b0_cn   = nor2(b0_ab, b0_cp);
    assign b0_cout = nor2(b0_cn, b0_cn);

    // ---------------------------------------------------------------- NOR path, bit 1
    logic b1_n1, b1_n2, b1_n3, b1_xn;
    logic b1_m1, b1_m2, b1_m3, b1_sum;
    logic b1_na, b1_nb, b1_ab, b1_nc, b1_cp, b1_cn, b1_cout;

    assign b1_n1   = nor2(a[1], b[1]);
    assign b1_n2   = nor2(a[1], b1_n1);
    assign b1_n3   = nor2(b[1], b1_n1);
    assign b1_xn   = nor2(b1_n2, b1_n3);
    assign b1_m1   = nor2(b1_xn, b0_cout);
    assign b1_m2   = nor2(b1_xn, b1_m1);
    assign b1_m3   = nor2(b0_cout, b1_m1);
    assign b1_sum  = nor2(b1_m2, b1_m3);

    assign b1_na   = nor2(a[1], a[1]);
    assign b1_nb   = nor2(b[1], b[1]);
    assign b1_ab   = nor2(b1_na, b1_nb);
    assign b1_nc   = nor2(b0_cout, b0_cout);
    assign b1_cp   = nor2(b1_nc, b1_xn);
    assign b1_cn   = nor2(b1_ab, b1_cp);
    assign b1_cout = nor2(b1_cn, b1_cn);

    logic [2:0] nor_res;
    assign nor_res = {b1_cout, b1_sum, b0_sum};

    // ---------------------------------------------------------------- reference path
    logic [2:0] ref_res;
    assign ref_res = {1'b0, a} + {1'b0, b} + {2'b00, cin};

    // ---------------------------------------------------------------- registers
    logic             out_valid_d, out_valid_q;
    logic [1:0]       sum_nor_d, sum_nor_q;
    logic             cout_nor_d, cout_nor_q;
    logic [1:0]       sum_ref_d, sum_ref_q;
    logic             cout_ref_d, cout_ref_q;
    logic             mismatch_d, mismatch_q;
    logic             err_sticky_d, err_sticky_q;
    logic [CNT_W-1:0] err_count_d, err_count_q;

    always_comb begin
        out_valid_d  = in_valid;
        sum_nor_d    = sum_nor_q;
        cout_nor_d   = cout_nor_q;
        sum_ref_d    = sum_ref_q;
        cout_ref_d   = cout_ref_q;
        mismatch_d   = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;

        if (in_valid) begin
            sum_nor_d  = nor_res[1:0];
            cout_nor_d = nor_res[2];
            sum_ref_d  = ref_res[1:0];
            cout_ref_d = ref_res[2];
            mismatch_d = (nor_res != ref_res);
        end

        // Sticky flag and counter advance on the same edge that loads mismatch
        if (mismatch_d) begin
            err_sticky_d = 1'b1;
            if (err_count_q != {CNT_W{1'b1}}) begin
                err_count_d = err_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            sum_nor_q    <= 2'b00;
            cout_nor_q   <= 1'b0;
            sum_ref_q    <= 2'b00;
            cout_ref_q   <= 1'b0;
            mismatch_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            sum_nor_q    <= sum_nor_d;
            cout_nor_q   <= cout_nor_d;
            sum_ref_q    <= sum_ref_d;
            cout_ref_q   <= cout_ref_d;
            mismatch_q   <= mismatch_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign sum_nor    = sum_nor_q;
    assign cout_nor   = cout_nor_q;
    assign sum_ref    = sum_ref_q;
    assign cout_ref   = cout_ref_q;
    assign mismatch   = mismatch_q;
    assign err_sticky = err_sticky_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_nor_adder2_dual.sv
// Directed bench for nor_adder2_dual: reset, vectors, exhaustive sweep, valid gap,
// stuck-at fault on the NOR path with counter saturation, and asynchronous reset.
module tb_nor_adder2_dual;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] a;
    logic [1:0] b;
    logic       cin;
    logic       out_valid;
    logic [1:0] sum_nor;
    logic       cout_nor;
    logic [1:0] sum_ref;
    logic       cout_ref;
    logic       mismatch;
    logic       err_sticky;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    nor_adder2_dual #(
        .GATE_DELAY (0),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .out_valid  (out_valid),
        .sum_nor    (sum_nor),
        .cout_nor   (cout_nor),
        .sum_ref    (sum_ref),
        .cout_ref   (cout_ref),
        .mismatch   (mismatch),
        .err_sticky (err_sticky),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".nor"}, {29'd0, cout_nor, sum_nor}, 32'd0);
        check({tag, ".ref"}, {29'd0, cout_ref, sum_ref}, 32'd0);
        check({tag, ".mismatch"}, {31'd0, mismatch}, 32'd0);
        check({tag, ".err_sticky"}, {31'd0, err_sticky}, 32'd0);
        check({tag, ".err_count"}, {24'd0, err_count}, 32'd0);
    endtask

    task automatic check_result(input string tag, input logic [2:0] exp);
        check({tag, ".nor"}, {29'd0, cout_nor, sum_nor}, {29'd0, exp});
        check({tag, ".ref"}, {29'd0, cout_ref, sum_ref}, {29'd0, exp});
        check({tag, ".mismatch"}, {31'd0, mismatch}, 32'd0);
    endtask

    // {a[1:0], b[1:0], cin, expected {cout, sum}}
    logic [7:0] dvec [4] = '{8'b11_10_1_110, 8'b10_00_0_010, 8'b10_10_1_101, 8'b00_01_0_001};

    initial begin
        logic [7:0] v;
        logic [4:0] e;
        int         valid_run;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 2'd0;
        b        = 2'd0;
        cin      = 1'b0;

        // Reset held for three cycles, released between edges
        repeat (3) tick();
        check_all_zero("rst_hold");
        rst_n = 1'b1;
        tick();
        check_all_zero("rst_rel");

        // Directed vectors
        for (int i = 0; i < 4; i++) begin
            v        = dvec[i];
            in_valid = 1'b1;
            a        = v[7:6];
            b        = v[5:4];
            cin      = v[3];
            tick();
            check($sformatf("dir%0d.valid", i), {31'd0, out_valid}, 32'd1);
            check_result($sformatf("dir%0d", i), v[2:0]);
        end

        // Exhaustive sweep, back-to-back
        valid_run = 0;
        for (int i = 0; i < 32; i++) begin
            e        = 5'(i);
            in_valid = 1'b1;
            a        = e[4:3];
            b        = e[2:1];
            cin      = e[0];
            tick();
            if (out_valid === 1'b1) valid_run++;
            check_result($sformatf("exh%0d", i), 3'(int'(e[4:3]) + int'(e[2:1]) + int'(e[0])));
        end
        check("exh.valid_run", valid_run, 32);
        check("exh.err_sticky", {31'd0, err_sticky}, 32'd0);

        // Valid gap: result 7 must be held while operands change
        in_valid = 1'b1;
        a        = 2'd3;
        b        = 2'd3;
        cin      = 1'b1;
        tick();
        check_result("gap.load", 3'd7);
        in_valid = 1'b0;
        a        = 2'd0;
        b        = 2'd1;
        cin      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("gap%0d.valid", i), {31'd0, out_valid}, 32'd0);
            check_result($sformatf("gap%0d", i), 3'd7);
        end

        // Stuck-at-0 on the bit-1 sum NOR: 1+1+1 gives NOR 3'b001 against reference 3'b011
        force dut.b1_sum = 1'b0;
        in_valid = 1'b1;
        a        = 2'd1;
        b        = 2'd1;
        cin      = 1'b1;
        tick();
        check("flt.nor", {29'd0, cout_nor, sum_nor}, 32'd1);
        check("flt.ref", {29'd0, cout_ref, sum_ref}, 32'd3);
        check("flt.mismatch", {31'd0, mismatch}, 32'd1);
        check("flt.err_sticky", {31'd0, err_sticky}, 32'd1);
        check("flt.err_count1", {24'd0, err_count}, 32'd1);
        tick();
        check("flt.err_count2", {24'd0, err_count}, 32'd2);
        repeat (252) tick();
        check("flt.err_count254", {24'd0, err_count}, 32'd254);
        tick();
        check("flt.err_count255", {24'd0, err_count}, 32'd255);
        repeat (5) tick();
        check("flt.saturated", {24'd0, err_count}, 32'hFF);
        release dut.b1_sum;

        // Healthy cycle after release: no new mismatch, sticky and count held
        tick();
        check_result("post_flt", 3'd3);
        check("post_flt.err_sticky", {31'd0, err_sticky}, 32'd1);
        check("post_flt.err_count", {24'd0, err_count}, 32'hFF);

        // Asynchronous reset between edges while out_valid is high
        a   = 2'd2;
        b   = 2'd1;
        cin = 1'b1;
        tick();
        check("async.pre_valid", {31'd0, out_valid}, 32'd1);
        check_result("async.pre", 3'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async");
        #3;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check_all_zero("async_rel");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/nor_adder2_dual.md
Name: nor_adder2_dual

Overview:
- Registered 2-bit adder with carry-in. Computes the same sum on two independent datapaths:
  - a structural path built only from 2-input NOR gates;
  - a behavioural reference path using a plain arithmetic add.
- Outputs of both paths are registered and compared every valid cycle. Mismatches are flagged and counted.
- Serves as a self-checking arithmetic slice and as a gate-level vs behavioural equivalence monitor.

Parameters:
- GATE_DELAY, default 0, per-NOR propagation delay in ns. Simulation only; ignored by synthesis; must never change registered results when clock period > 20*GATE_DELAY.
- CNT_W, default 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- a  input  2  operand A (a[1] MSB)
- b  input  2  operand B
- cin  input  1  carry-in
- out_valid  output  1  registered results valid
- sum_nor  output  2  NOR-path sum bits
- cout_nor  output  1  NOR-path carry-out
- sum_ref  output  2  reference-path sum bits
- cout_ref  output  1  reference-path carry-out
- mismatch  output  1  NOR and reference results differ this valid cycle
- err_sticky  output  1  set on any mismatch since reset
- err_count  output  CNT_W  saturating count of mismatching valid cycles

Behaviour:
- Reset:
  - rst_n low asynchronously clears every output and internal register to 0.
  - Release is synchronous to the next clk edge.
- Function:
  - {cout, sum[1:0]} = a + b + cin, a 3-bit result with range 0..7.
- NOR path:
  - Ripple of two full adders; bit 0 carry feeds bit 1.
  - Only 2-input NOR instances (or NOR expressions) with GATE_DELAY per gate; no other operators.
  - Inversion is NOR with both inputs tied together.
- Reference path:
  - Single continuous addition of zero-extended operands.
- Latency: one cycle. On a rising clk with in_valid=1:
  - sum_nor, cout_nor, sum_ref, cout_ref are loaded;
  - out_valid=1;
  - mismatch = ({cout_nor,sum_nor} != {cout_ref,sum_ref}), computed from the combinational results of that cycle.
- Cycles with in_valid=0:
  - out_valid=0 and mismatch=0;
  - result registers hold their previous values.
- err_sticky:
  - set on any registered mismatch=1;
  - cleared only by reset.
- err_count:
  - increments on each cycle that loads mismatch=1;
  - saturates at all-ones and never wraps.
- Back-to-back valid inputs are accepted every cycle. No backpressure, no stall.
- Reset asserted mid-stream: outputs go to 0 immediately; an in-flight result is discarded.
- In a correct implementation mismatch is never 1. The compare logic must still be real, not constant-folded, so fault injection on the NOR path is detected.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> all outputs 0; err_count=0.
- Directed vectors, each with in_valid=1, checked one cycle later on both paths with mismatch=0:
  - a=3, b=2, cin=1 -> cout=1, sum=2'b10 (6)
  - a=2, b=0, cin=0 -> cout=0, sum=2'b10 (2)
  - a=2, b=2, cin=1 -> cout=1, sum=2'b01 (5)
  - a=0, b=1, cin=0 -> cout=0, sum=2'b01 (1)
- Exhaustive: all 32 combinations of {a, b, cin}, back-to-back -> each result equals a+b+cin; out_valid high for 32 consecutive cycles; err_sticky stays 0.
- Valid gap: in_valid=0 for 2 cycles after a=3, b=3, cin=1 -> out_valid=0; sum=2'b11 and cout=1 (7) held.
- Fault injection: force one internal NOR output of bit 1 stuck-at-0, then apply a=1, b=1, cin=1 -> mismatch=1, err_sticky=1, err_count increments. Repeat past 255 events -> err_count saturates at 8'hFF.
- Async reset mid-stream: assert rst_n between clock edges while out_valid=1 -> outputs clear immediately without a clock edge.
